// File: rtl/fetch_pkg.sv
// Shared constants and the default prefetch queue entry type for the fetch unit.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W  = 64;
    localparam int unsigned DEF_INSTR_W = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry circular buffer with a single-cycle flush.
// The caller guarantees no push when full (unless popping) and no pop when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head_data,
    output logic [CNT_W-1:0] count
);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the data array has no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[tail_q] <= push_data;
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Instruction prefetcher: walks the fetch PC, fills the prefetch queue from
// instruction memory and presents the head entry to decode; redirects flush everything.
module prefetch_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       INSTR_W  = DEF_INSTR_W,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         startup,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [INSTR_W-1:0]           imem_rdata,
    output logic                         imem_req,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         dec_valid,
    input  logic                         dec_ready,
    output logic [INSTR_W-1:0]           dec_instr,
    output logic [ADDR_W-1:0]            dec_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned       CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  FULL    = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] PC_MASK = ~(ADDR_W'(INSTR_BYTES - 1));

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pop;
    entry_t            push_entry;
    entry_t            head_entry;

    assign imem_addr = pc_q;
    assign dec_valid = (count != '0) && !redirect_valid;
    assign pop       = dec_valid && dec_ready;
    // A pop frees a slot in the same cycle, so a full queue still streams at one per cycle.
    assign imem_req  = !startup && !redirect_valid && ((count < FULL) || pop);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) pc_d = redirect_pc & PC_MASK;
        else if (imem_req)  pc_d = pc_q + STEP;
    end

    always_ff @(posedge clk or posedge startup) begin
        if (startup) pc_q <= RESET_PC;
        else         pc_q <= pc_d;
    end

    assign push_entry = '{pc: pc_q, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (startup),
        .flush     (redirect_valid),
        .push      (imem_req),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (count)
    );

    assign dec_instr = head_entry.instr;
    assign dec_pc    = head_entry.pc;

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Self-checking bench for prefetch_fetch_unit against a queue-based reference model.
module tb_prefetch_fetch_unit;

    localparam int          ADDR_W   = 64;
    localparam int          INSTR_W  = 32;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic              clk = 1'b0;
    logic              startup;
    logic [63:0]       imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_req;
    logic              redirect_valid;
    logic [63:0]       redirect_pc;
    logic              dec_valid;
    logic              dec_ready;
    logic [31:0]       dec_instr;
    logic [63:0]       dec_pc;
    logic [2:0]        count;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        model_q[$];
    logic [63:0] model_pc;
    int          n_vectors     = 0;
    int          n_miscompares = 0;

    prefetch_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .startup        (startup),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_req       (imem_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .count          (count)
    );

    always #5 clk = ~clk;

    // Instruction memory: a fixed scramble of the address, readable the same cycle.
    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
    endfunction

    assign imem_rdata = instr_of(imem_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_pc = RESET_PC;
    endtask

    // Entered just after a falling edge; applies inputs, checks outputs against
    // the model, advances the model across the next rising edge, returns at the next falling edge.
    task automatic cycle(input logic rv, input logic [63:0] rpc, input logic rdy);
        logic exp_valid, exp_pop, exp_req;
        redirect_valid = rv;
        redirect_pc    = rpc;
        dec_ready      = rdy;
        #1;
        exp_valid = (model_q.size() != 0) && !rv;
        exp_pop   = exp_valid && rdy;
        exp_req   = !rv && ((model_q.size() < DEPTH) || exp_pop);
        check("count",     64'(count),     64'(model_q.size()));
        check("dec_valid", 64'(dec_valid), 64'(exp_valid));
        check("imem_req",  64'(imem_req),  64'(exp_req));
        check("imem_addr", imem_addr,      model_pc);
        if (exp_valid) begin
            check("dec_pc",    dec_pc,         model_q[0].pc);
            check("dec_instr", 64'(dec_instr), 64'(model_q[0].instr));
        end
        if (rv) begin
            model_q.delete();
            model_pc = {rpc[63:2], 2'b00};
        end else begin
            if (exp_pop) void'(model_q.pop_front());
            if (exp_req) begin
                model_q.push_back('{pc: model_pc, instr: instr_of(model_pc)});
                model_pc = model_pc + 64'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        startup        = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b1;
        @(negedge clk);
        #1;
        check("rst_count",     64'(count),     64'd0);
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        check("rst_imem_req",  64'(imem_req),  64'd0);
        check("rst_imem_addr", imem_addr,      RESET_PC);
        startup = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        // Streaming from reset with decode always ready.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);

        // Decode stalled: queue fills and fetch stops at 16.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b0);
        check("full_count",    64'(count),    64'd4);
        check("full_imem_req", 64'(imem_req), 64'd0);
        check("full_addr",     imem_addr,     64'd16);
        cycle(1'b0, '0, 1'b1);
        check("full_pushpop_count", 64'(count), 64'd4);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);

        // Redirect with three entries queued.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
        check("pre_redir_count", 64'(count), 64'd3);
        cycle(1'b1, 64'h103, 1'b0);
        check("redir_count", 64'(count), 64'd0);
        check("redir_addr",  imem_addr,  64'h100);
        cycle(1'b0, '0, 1'b1);
        check("redir_head_pc", dec_pc, 64'h100);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);

        // Back-to-back redirects: the last one wins.
        cycle(1'b1, 64'h2000, 1'b1);
        cycle(1'b1, 64'h3006, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

        // Asynchronous startup pulse between edges.
        #1 startup = 1'b1;
        #1;
        check("async_count",     64'(count),     64'd0);
        check("async_dec_valid", 64'(dec_valid), 64'd0);
        check("async_imem_req",  64'(imem_req),  64'd0);
        check("async_imem_addr", imem_addr,      RESET_PC);
        #1 startup = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);

        // Pointer wrap with random decode backpressure.
        for (int i = 0; i < 3 * DEPTH + 1; i++) cycle(1'b0, '0, 1'($urandom_range(0, 1)));

        // PC wraps past the top of the address space.
        cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("wrap_dec_pc", dec_pc, 64'h0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);

        // Mixed random traffic with occasional redirects.
        for (int i = 0; i < 300; i++) begin
            logic        rv;
            logic [63:0] rpc;
            rv  = ($urandom_range(0, 19) == 0);
            rpc = {$urandom, $urandom};
            cycle(rv, rpc, 1'($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/prefetch_fetch_unit.md
PREFETCH_FETCH_UNIT -- requirements
Module: prefetch_fetch_unit

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 64, meaning PC and instruction-memory address width in bits.
REQ-002 The block SHALL take parameter INSTR_W, default 32, meaning instruction word width in bits.
REQ-003 The block SHALL take parameter DEPTH, default 4, meaning prefetch queue entries (power of two, >= 2).
REQ-004 The block SHALL take parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port startup, input, 1, meaning reset, asynchronous and active-high.
REQ-007 The block SHALL have port imem_addr, output, ADDR_W, meaning current fetch PC to instruction memory.
REQ-008 The block SHALL have port imem_rdata, input, INSTR_W, meaning instruction word at imem_addr, valid the same cycle.
REQ-009 The block SHALL have port imem_req, output, 1, meaning imem_rdata is captured this cycle.
REQ-010 The block SHALL have port redirect_valid, input, 1, meaning taken branch / flush request.
REQ-011 The block SHALL have port redirect_pc, input, ADDR_W, meaning branch target.
REQ-012 The block SHALL have port dec_valid, output, 1, meaning head entry is presented to decode.
REQ-013 The block SHALL have port dec_ready, input, 1, meaning decode accepts head entry.
REQ-014 The block SHALL have port dec_instr, output, INSTR_W, meaning head instruction.
REQ-015 The block SHALL have port dec_pc, output, ADDR_W, meaning PC of head instruction.
REQ-016 The block SHALL have port count, output, clog2(DEPTH+1), meaning current queue occupancy.

Function
REQ-017 imem_addr SHALL equal the registered fetch PC.
REQ-018 imem_req SHALL be 1 when redirect_valid=0 and (count<DEPTH or a pop occurs this cycle), else 0.
REQ-019 On imem_req=1, the block SHALL enqueue {imem_addr, imem_rdata} at the tail and advance the fetch PC by 4, modulo 2^ADDR_W.
REQ-020 dec_valid SHALL be (count!=0) and redirect_valid=0; a pop occurs when dec_valid and dec_ready are both 1.
REQ-021 dec_instr/dec_pc SHALL come combinationally from the head entry; when dec_valid=0 their values are don't-care.
REQ-022 A simultaneous push and pop SHALL leave count unchanged, including at count=DEPTH (full) and at count=1.
REQ-023 Head and tail pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow below 0.
REQ-024 redirect_valid=1 SHALL take priority over push and pop: at the next edge count=0, pointers=0, fetch PC = redirect_pc with bits [1:0] forced to 0.
REQ-025 Back-to-back redirects SHALL each take effect; the last one wins, and no entry is enqueued during any redirect cycle.
REQ-026 Fetch-to-decode latency SHALL be one cycle: an instruction fetched in cycle N is at the head no earlier than cycle N+1.
REQ-027 With dec_ready held at 1 and no redirects, steady-state throughput SHALL be one instruction per cycle.

Reset
REQ-028 While startup=1 (asynchronously, including mid-operation), the block SHALL hold fetch PC=RESET_PC, count=0, head=tail=0, dec_valid=0, imem_req=0.
REQ-029 Queue data storage SHALL NOT require reset.
REQ-030 On the first edge after startup falls, the block SHALL capture the instruction at RESET_PC.

Structure
REQ-031 Package fetch_pkg SHALL hold the ADDR_W/INSTR_W defaults, the INSTR_BYTES=4 constant, and the typedef of the queue entry struct {pc, instr}.
REQ-032 Queue storage and pointers SHALL be one sub-module, fetch_fifo (parametrised on DEPTH and entry type), with a flush input; the PC/redirect logic stays in the top.

Verification
REQ-033 Reset, then dec_ready=1 and no redirect: dec_pc sequence SHALL be 0,4,8,12…; dec_valid SHALL first be 1 in cycle 1 after release.
REQ-034 With dec_ready=0 for 8 cycles: count SHALL saturate at 4 and imem_req SHALL fall to 0 with imem_addr=16; on raising dec_ready, a pop and push SHALL occur in the same cycle with count staying at 4.
REQ-035 With queue at count=3 and redirect_valid=1, redirect_pc=0x103: the next cycle SHALL show count=0, dec_valid=0, and imem_addr=0x100; the following cycle SHALL present dec_pc=0x100.
REQ-036 Pulsing startup=1 mid-stream, asynchronously between edges: outputs SHALL clear immediately, and fetch SHALL resume at RESET_PC.
REQ-037 Run 3*DEPTH+1 push/pop cycles with random dec_ready: the dec_pc order SHALL match the fetch order across pointer wrap, with no duplication or loss.
REQ-038 With the fetch PC set to 2^ADDR_W-4 via redirect: the next fetched dec_pc SHALL wrap to 0.
